fsm_seq_monitor: RTL and testbench

- Passive checker sitting on the output side of a cyclic 2-bit sequence generator.
- The generator's legal cycle is 0->1->2->3->0, with out=1 exactly while state==2.
- The monitor samples state/out each valid cycle, flags illegal transitions, stuck states and out mismatches, and counts completed cycles.
- Used in formal/sim harnesses as the observer end of the generator interface; it has no influence on the DUT.

---
 rtl/fsm_seq_monitor.sv | 166 ++++++++++++++++
 tb/tb_fsm_seq_monitor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_monitor.sv
// Passive observer for a cyclic 0->1->2->3 generator: flags illegal steps, stuck states,
// output mismatches and a bad first state; counts completed cycles. Results register on the sampling edge.
module fsm_seq_monitor #(
    parameter int STUCK_LIMIT = 4,
    parameter int CNT_W       = 8,
    parameter int HALT_ON_ERR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_valid,
    input  logic [1:0]       mon_state,
    input  logic             mon_out,
    input  logic             clear,
    output logic             err_illegal,
    output logic             err_stuck,
    output logic             err_out,
    output logic             err_init,
    output logic             err_any,
    output logic [2:0]       first_err_code,
    output logic [1:0]       first_err_state,
    output logic [CNT_W-1:0] wrap_count,
    output logic [1:0]       mon_state_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_err_illegal;
    logic             r_err_stuck;
    logic             r_err_out;
    logic             r_err_init;
    logic             r_err_any;
    logic [2:0]       r_first_code;
    logic [1:0]       r_first_state;
    logic [CNT_W-1:0] r_wrap_count;
    logic [1:0]       r_mon_state_q;
    logic [7:0]       r_hold_cnt;

    logic             w_sample;
    logic             w_e_init;
    logic             w_e_ill;
    logic             w_e_stk;
    logic             w_e_out;
    logic             w_err_new;
    logic             w_wrap_inc;
    logic [7:0]       w_hold_nxt;
    logic [7:0]       w_hold_inc;
    logic [1:0]       w_succ;
    logic [2:0]       w_code;

    assign w_succ     = r_mon_state_q + 2'd1;
    assign w_hold_inc = (r_hold_cnt == 8'hFF) ? 8'hFF : r_hold_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_e_init    = 1'b0;
        w_e_ill     = 1'b0;
        w_e_stk     = 1'b0;
        w_e_out     = 1'b0;
        w_wrap_inc  = 1'b0;
        w_hold_nxt  = r_hold_cnt;
        if (mon_valid && !clear) begin
            case (r_state)
                S_IDLE: begin
                    w_sample   = 1'b1;
                    w_e_init   = (mon_state != 2'd0);
                    w_e_out    = (mon_out != (mon_state == 2'd2));
                    w_hold_nxt = 8'd0;
                end
                S_TRACK: begin
                    w_sample = 1'b1;
                    w_e_out  = (mon_out != (mon_state == 2'd2));
                    if (mon_state == w_succ) begin
                        w_hold_nxt = 8'd0;
                        w_wrap_inc = (r_mon_state_q == 2'd3);
                    end else if (mon_state == r_mon_state_q) begin
                        // hold count H means H+1 consecutive samples of this state
                        w_hold_nxt = w_hold_inc;
                        w_e_stk    = (int'(w_hold_inc) >= STUCK_LIMIT);
                    end else begin
                        w_e_ill    = 1'b1;
                        w_hold_nxt = 8'd0;
                    end
                end
                default: ;
            endcase
        end
        w_err_new = w_e_init | w_e_ill | w_e_stk | w_e_out;
        if (w_sample)
            w_state_nxt = (w_err_new && (HALT_ON_ERR != 0)) ? S_HALT : S_TRACK;
        if (clear)
            w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_code = 3'd0;
        if (w_e_init)      w_code = 3'd4;
        else if (w_e_ill)  w_code = 3'd1;
        else if (w_e_stk)  w_code = 3'd2;
        else if (w_e_out)  w_code = 3'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_illegal <= 1'b0;
            r_err_stuck   <= 1'b0;
            r_err_out     <= 1'b0;
            r_err_init    <= 1'b0;
            r_err_any     <= 1'b0;
            r_first_code  <= 3'd0;
            r_first_state <= 2'd0;
            r_wrap_count  <= '0;
            r_mon_state_q <= 2'd0;
            r_hold_cnt    <= 8'd0;
        end else if (clear) begin
            r_err_illegal <= 1'b0;
            r_err_stuck   <= 1'b0;
            r_err_out     <= 1'b0;
            r_err_init    <= 1'b0;
            r_err_any     <= 1'b0;
            r_first_code  <= 3'd0;
            r_first_state <= 2'd0;
            r_wrap_count  <= '0;
            r_hold_cnt    <= 8'd0;
        end else if (w_sample) begin
            r_err_illegal <= r_err_illegal | w_e_ill;
            r_err_stuck   <= r_err_stuck   | w_e_stk;
            r_err_out     <= r_err_out     | w_e_out;
            r_err_init    <= r_err_init    | w_e_init;
            r_err_any     <= r_err_any     | w_err_new;
            if (w_err_new && !r_err_any) begin
                r_first_code  <= w_code;
                r_first_state <= mon_state;
            end
            if (w_wrap_inc && (r_wrap_count != {CNT_W{1'b1}}))
                r_wrap_count <= r_wrap_count + 1'b1;
            r_mon_state_q <= mon_state;
            r_hold_cnt    <= w_hold_nxt;
        end
    end

    assign err_illegal     = r_err_illegal;
    assign err_stuck       = r_err_stuck;
    assign err_out         = r_err_out;
    assign err_init        = r_err_init;
    assign err_any         = r_err_any;
    assign first_err_code  = r_first_code;
    assign first_err_state = r_first_state;
    assign wrap_count      = r_wrap_count;
    assign mon_state_q     = r_mon_state_q;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Directed bench for fsm_seq_monitor: one halting instance and one non-halting instance share stimulus.
module tb_fsm_seq_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mon_valid = 1'b0;
    logic [1:0] mon_state = 2'd0;
    logic       mon_out = 1'b0;
    logic       clear = 1'b0;

    logic       h_ill, h_stk, h_out, h_init, h_any;
    logic [2:0] h_code;
    logic [1:0] h_fst, h_q;
    logic [7:0] h_wrap;

    logic       n_ill, n_stk, n_out, n_init, n_any;
    logic [2:0] n_code;
    logic [1:0] n_fst, n_q;
    logic [7:0] n_wrap;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fsm_seq_monitor #(.STUCK_LIMIT(4), .CNT_W(8), .HALT_ON_ERR(1)) u_dut (
        .clk(clk), .rst(rst), .mon_valid(mon_valid), .mon_state(mon_state),
        .mon_out(mon_out), .clear(clear),
        .err_illegal(h_ill), .err_stuck(h_stk), .err_out(h_out), .err_init(h_init),
        .err_any(h_any), .first_err_code(h_code), .first_err_state(h_fst),
        .wrap_count(h_wrap), .mon_state_q(h_q)
    );

    fsm_seq_monitor #(.STUCK_LIMIT(4), .CNT_W(8), .HALT_ON_ERR(0)) u_dut_nh (
        .clk(clk), .rst(rst), .mon_valid(mon_valid), .mon_state(mon_state),
        .mon_out(mon_out), .clear(clear),
        .err_illegal(n_ill), .err_stuck(n_stk), .err_out(n_out), .err_init(n_init),
        .err_any(n_any), .first_err_code(n_code), .first_err_state(n_fst),
        .wrap_count(n_wrap), .mon_state_q(n_q)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mon_valid = 1'b0;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One valid sample with the correct generator out unless overridden.
    task automatic samp(input logic [1:0] st, input logic o);
        mon_valid = 1'b1;
        mon_state = st;
        mon_out   = o;
        @(posedge clk);
        #1 mon_valid = 1'b0;
    endtask

    task automatic good(input logic [1:0] st);
        samp(st, st == 2'd2);
    endtask

    logic [1:0] seq9 [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        do_reset();
        chk("rst_any",   h_any, 0);
        chk("rst_code",  h_code, 0);
        chk("rst_wrap",  h_wrap, 0);
        chk("rst_q",     h_q, 0);
        chk("rst_flags", {h_ill, h_stk, h_out, h_init}, 0);

        // legal run with an invalid gap (garbage state) after the second sample
        for (int i = 0; i < 9; i++) begin
            good(seq9[i]);
            if (i == 1) begin
                mon_state = 2'd3;
                repeat (6) @(posedge clk);
                #1;
                chk("gap_q_held", h_q, 1);
            end
        end
        chk("legal_any",  h_any, 0);
        chk("legal_stk",  h_stk, 0);
        chk("legal_wrap", h_wrap, 2);
        chk("legal_q",    h_q, 0);
        chk("legal_nh_wrap", n_wrap, 2);

        // asynchronous reset between edges
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_wrap", h_wrap, 0);
        chk("arst_q",    h_q, 0);
        #1 rst = 1'b0;

        // stuck at 3
        do_reset();
        good(0); good(1); good(2); good(3); good(3); good(3); good(3);
        chk("stuck_early", h_stk, 0);
        good(3);
        chk("stuck_flag",  h_stk, 1);
        chk("stuck_any",   h_any, 1);
        chk("stuck_code",  h_code, 2);
        chk("stuck_state", h_fst, 3);
        chk("stuck_ill",   h_ill, 0);

        // illegal jump 1->3, then a 3->0 that only the non-halting copy counts
        do_reset();
        good(0); good(1); good(3);
        chk("ill_flag",  h_ill, 1);
        chk("ill_code",  h_code, 1);
        chk("ill_state", h_fst, 3);
        good(0);
        chk("ill_halt_wrap", h_wrap, 0);
        chk("ill_halt_q",    h_q, 3);
        chk("ill_nh_wrap",   n_wrap, 1);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_err_any",  h_any, 0);
        chk("arst_err_code", h_code, 0);
        #1 rst = 1'b0;

        // out mismatch at state 2
        do_reset();
        good(0); good(1); samp(2, 1'b0);
        chk("out_flag", h_out, 1);
        chk("out_code", h_code, 3);
        chk("out_nh_code", n_code, 3);
        samp(3, 1'b1);
        chk("out_nh_code_kept", n_code, 3);
        chk("out_nh_flag",      n_out, 1);
        chk("out_nh_ill",       n_ill, 0);

        // bad first state, then clear (same-cycle sample ignored), then TRACK
        do_reset();
        samp(2, 1'b1);
        chk("init_flags", {h_ill, h_stk, h_out, h_init}, 4'b0001);
        chk("init_code",  h_code, 4);
        chk("init_state", h_fst, 2);
        mon_valid = 1'b1;
        mon_state = 2'd3;
        mon_out   = 1'b1;
        clear     = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        mon_valid = 1'b0;
        chk("clr_any",   h_any, 0);
        chk("clr_code",  h_code, 0);
        chk("clr_state", h_fst, 0);
        chk("clr_flags", {h_ill, h_stk, h_out, h_init}, 0);
        good(0);
        chk("clr_after0_any", h_any, 0);
        good(2);
        chk("clr_track_ill",  h_ill, 1);
        chk("clr_track_code", h_code, 1);
        chk("clr_track_init", h_init, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
